// File: rtl/s2_ctrl_pkg.sv
// Shared decode constants and bundle types for the stage-2 control pipe.
// Opcode/funct3 values and ALU select encodings used across the core.
package s2_ctrl_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRWI = 3'b101;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SLL   = 4'd1;
  localparam logic [3:0] ALU_SLT   = 4'd2;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SRL   = 4'd5;
  localparam logic [3:0] ALU_OR    = 4'd6;
  localparam logic [3:0] ALU_AND   = 4'd7;
  localparam logic [3:0] ALU_CSRW  = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd11;
  localparam logic [3:0] ALU_SUB   = 4'd12;
  localparam logic [3:0] ALU_SRA   = 4'd13;
  localparam logic [3:0] ALU_PASSB = 4'd15;

  typedef struct packed {
    logic [3:0] alu_sel;
    logic       a_sel;
    logic       b_sel;
    logic       brun;
    logic       mem_wen;
    logic       csr_we;
    logic       is_load;
    logic       wr;
    logic       use_rs1;
    logic       use_rs2;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } dec_t;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       ld;
    logic [4:0] rd;
  } hist_t;

endpackage

// File: rtl/s2_ctrl_decode.sv
// Combinational RV32I/Zicsr control decoder for the offered instruction.
// Produces datapath controls plus register-use info for forwarding.
module s2_ctrl_decode
  import s2_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] op;
  logic [2:0] f3;
  logic       f30;
  logic       is_lui, is_auipc, is_jal, is_jalr;
  logic       is_br, is_ld, is_st, is_opi, is_op, is_sys;
  logic [3:0] arith;
  logic [3:0] csr_alu;
  logic       unused_bits;

  assign op  = instr[6:0];
  assign f3  = instr[14:12];
  assign f30 = instr[30];

  assign is_lui   = (op == OP_LUI);
  assign is_auipc = (op == OP_AUIPC);
  assign is_jal   = (op == OP_JAL);
  assign is_jalr  = (op == OP_JALR);
  assign is_br    = (op == OP_BRANCH);
  assign is_ld    = (op == OP_LOAD);
  assign is_st    = (op == OP_STORE);
  assign is_opi   = (op == OP_IMM);
  assign is_op    = (op == OP_REG);
  assign is_sys   = (op == OP_SYSTEM);

  assign unused_bits = ^{instr[31], instr[29:25]};

  // SUB only exists as R-type; SRA/SRAI both use bit 30
  always_comb begin
    arith = ALU_ADD;
    case (f3)
      F3_ADD:  arith = (is_op && f30) ? ALU_SUB : ALU_ADD;
      F3_SLL:  arith = ALU_SLL;
      F3_SLT:  arith = ALU_SLT;
      F3_SLTU: arith = ALU_SLTU;
      F3_XOR:  arith = ALU_XOR;
      F3_SR:   arith = f30 ? ALU_SRA : ALU_SRL;
      F3_OR:   arith = ALU_OR;
      F3_AND:  arith = ALU_AND;
      default: arith = ALU_ADD;
    endcase
  end

  always_comb begin
    csr_alu = ALU_ADD;
    case (f3)
      F3_CSRRW:  csr_alu = ALU_CSRW;
      F3_CSRRWI: csr_alu = ALU_PASSB;
      default:   csr_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.brun    = instr[13];
    dec.b_sel   = 1'b1;
    dec.use_rs1 = 1'b1;
    unique case (1'b1)
      is_lui: begin
        dec.alu_sel = ALU_PASSB;
        dec.use_rs1 = 1'b0;
        dec.wr      = 1'b1;
      end
      is_auipc, is_jal: begin
        dec.a_sel   = 1'b1;
        dec.use_rs1 = 1'b0;
        dec.wr      = 1'b1;
      end
      is_jalr: dec.wr = 1'b1;
      is_br: begin
        dec.a_sel   = 1'b1;
        dec.use_rs2 = 1'b1;
      end
      is_ld: begin
        dec.is_load = 1'b1;
        dec.wr      = 1'b1;
      end
      is_st: begin
        dec.mem_wen = 1'b1;
        dec.use_rs2 = 1'b1;
      end
      is_opi: begin
        dec.alu_sel = arith;
        dec.wr      = 1'b1;
      end
      is_op: begin
        dec.alu_sel = arith;
        dec.b_sel   = 1'b0;
        dec.use_rs2 = 1'b1;
        dec.wr      = 1'b1;
      end
      is_sys: begin
        dec.alu_sel = csr_alu;
        dec.csr_we  = 1'b1;
        dec.wr      = 1'b1;
      end
      default: ;
    endcase
    if (instr[11:7] == 5'd0) dec.wr = 1'b0;
  end

endmodule

// File: rtl/s2_ctrl_pipe.sv
// Stage-2 control register with load-use stall and forwarding select.
// Output register counts as history distance 1 for operand matching.
module s2_ctrl_pipe
  import s2_ctrl_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int FWD_STAGES = 2,
  parameter  int LOAD_LAT   = 1,
  localparam int FW         = $clog2(FWD_STAGES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  input  logic [XLEN-1:0] alu_result,
  output logic            out_valid,
  output logic [3:0]      alu_sel,
  output logic            a_sel,
  output logic            b_sel,
  output logic            brun,
  output logic            mem_wen,
  output logic            csr_we,
  output logic            imem_ena,
  output logic [FW-1:0]   fwd_sel_a,
  output logic [FW-1:0]   fwd_sel_b,
  output logic            stall
);

  dec_t          dec;
  hist_t         cur;
  hist_t         hist [1:FWD_STAGES];
  hist_t         cand [1:FWD_STAGES];
  logic          cur_wr_q;
  logic          cur_ld_q;
  logic [4:0]    cur_rd_q;
  logic          pc30_q;
  logic [FW-1:0] ka, kb;
  logic          lda, ldb;
  logic          haz;
  logic          acc;
  logic          unused_bits;

  s2_ctrl_decode u_dec (
    .instr (instr_in),
    .dec   (dec)
  );

  assign cur = '{valid: out_valid, wr: cur_wr_q,
                 ld: cur_ld_q, rd: cur_rd_q};

  // descending scan so the nearest producer wins
  always_comb begin
    cand[1] = cur;
    for (int k = 2; k <= FWD_STAGES; k++)
      cand[k] = hist[k-1];
    ka  = '0;
    kb  = '0;
    lda = 1'b0;
    ldb = 1'b0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (cand[k].valid && cand[k].wr &&
          cand[k].rd == dec.rs1) begin
        ka  = FW'(k);
        lda = cand[k].ld;
      end
      if (cand[k].valid && cand[k].wr &&
          cand[k].rd == dec.rs2) begin
        kb  = FW'(k);
        ldb = cand[k].ld;
      end
    end
    if (!dec.use_rs1) begin
      ka  = '0;
      lda = 1'b0;
    end
    if (!dec.use_rs2) begin
      kb  = '0;
      ldb = 1'b0;
    end
  end

  assign haz = (lda && int'(ka) <= LOAD_LAT) ||
               (ldb && int'(kb) <= LOAD_LAT);
  assign stall    = in_valid && haz;
  assign in_ready = !stall;
  assign acc      = in_valid && !stall && !flush;

  assign imem_ena = out_valid && mem_wen &&
                    alu_result[31:29] == 3'b001 && pc30_q;

  assign unused_bits = ^{alu_result, pc_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= FWD_STAGES; k++)
        hist[k] <= '0;
      out_valid <= 1'b0;
      alu_sel   <= '0;
      a_sel     <= 1'b0;
      b_sel     <= 1'b0;
      brun      <= 1'b0;
      mem_wen   <= 1'b0;
      csr_we    <= 1'b0;
      fwd_sel_a <= '0;
      fwd_sel_b <= '0;
      cur_wr_q  <= 1'b0;
      cur_ld_q  <= 1'b0;
      cur_rd_q  <= '0;
      pc30_q    <= 1'b0;
    end else begin
      hist[1] <= cur;
      for (int k = 2; k <= FWD_STAGES; k++)
        hist[k] <= hist[k-1];
      out_valid <= acc;
      if (acc) begin
        alu_sel   <= dec.alu_sel;
        a_sel     <= dec.a_sel;
        b_sel     <= dec.b_sel;
        brun      <= dec.brun;
        mem_wen   <= dec.mem_wen;
        csr_we    <= dec.csr_we;
        fwd_sel_a <= ka;
        fwd_sel_b <= kb;
        cur_wr_q  <= dec.wr;
        cur_ld_q  <= dec.is_load;
        cur_rd_q  <= dec.rd;
        pc30_q    <= pc_in[30];
      end else begin
        alu_sel   <= '0;
        a_sel     <= 1'b0;
        b_sel     <= 1'b0;
        brun      <= 1'b0;
        mem_wen   <= 1'b0;
        csr_we    <= 1'b0;
        fwd_sel_a <= '0;
        fwd_sel_b <= '0;
        cur_wr_q  <= 1'b0;
        cur_ld_q  <= 1'b0;
        cur_rd_q  <= '0;
        pc30_q    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_s2_ctrl_pipe.sv
// Bench for s2_ctrl_pipe: slot-list reference model plus directed scenarios.
// Two instances (2-deep and 4-deep history) share one stimulus stream.
module tb_s2_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr_in = '0;
  logic [31:0] pc_in = '0;
  logic [31:0] alu_result = '0;

  logic       ov0, rdy0, a0, b0, br0, mw0, cw0, ie0, st0;
  logic [3:0] alu0;
  logic [1:0] fa0, fb0;
  logic       ov1, rdy1, a1, b1, br1, mw1, cw1, ie1, st1;
  logic [3:0] alu1;
  logic [2:0] fa1, fb1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  s2_ctrl_pipe u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .instr_in(instr_in), .pc_in(pc_in), .flush(flush),
    .alu_result(alu_result), .out_valid(ov0), .alu_sel(alu0),
    .a_sel(a0), .b_sel(b0), .brun(br0), .mem_wen(mw0),
    .csr_we(cw0), .imem_ena(ie0), .fwd_sel_a(fa0),
    .fwd_sel_b(fb0), .stall(st0)
  );

  s2_ctrl_pipe #(.FWD_STAGES(4), .LOAD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .instr_in(instr_in), .pc_in(pc_in), .flush(flush),
    .alu_result(alu_result), .out_valid(ov1), .alu_sel(alu1),
    .a_sel(a1), .b_sel(b1), .brun(br1), .mem_wen(mw1),
    .csr_we(cw1), .imem_ena(ie1), .fwd_sel_a(fa1),
    .fwd_sel_b(fb1), .stall(st1)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference model: slot k = instruction issued k cycles ago (slot 1 = output)
  bit          mv [1:4] = '{default: 1'b0};
  logic [31:0] mi [1:4] = '{default: 32'h0};
  logic [31:0] mpc = '0;
  int          ea0 = 0, eb0 = 0, ea1 = 0, eb1 = 0;
  bit          m_s, m_acc;

  function automatic bit writes(input logic [31:0] i);
    logic [6:0] o;
    o = i[6:0];
    if (i[11:7] == 5'd0) return 1'b0;
    return o == 7'h37 || o == 7'h17 || o == 7'h6f || o == 7'h67 ||
           o == 7'h03 || o == 7'h33 || o == 7'h13 || o == 7'h73;
  endfunction

  function automatic bit use1(input logic [31:0] i);
    logic [6:0] o;
    o = i[6:0];
    return !(o == 7'h37 || o == 7'h17 || o == 7'h6f);
  endfunction

  function automatic bit use2(input logic [31:0] i);
    logic [6:0] o;
    o = i[6:0];
    return o == 7'h33 || o == 7'h23 || o == 7'h63;
  endfunction

  function automatic int find(input logic [4:0] rs, input int fs);
    for (int k = 1; k <= fs; k++)
      if (mv[k] && writes(mi[k]) && mi[k][11:7] == rs) return k;
    return 0;
  endfunction

  function automatic bit mstall();
    int k;
    if (!in_valid) return 1'b0;
    if (use1(instr_in)) begin
      k = find(instr_in[19:15], 4);
      if (k == 1 && mi[1][6:0] == 7'h03) return 1'b1;
    end
    if (use2(instr_in)) begin
      k = find(instr_in[24:20], 4);
      if (k == 1 && mi[1][6:0] == 7'h03) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int exp_alu(input logic [31:0] i);
    logic [6:0] o;
    logic [2:0] f;
    o = i[6:0];
    f = i[14:12];
    if (o == 7'h37) return 15;
    if (o == 7'h73) return (f == 3'd1) ? 8 : (f == 3'd5) ? 15 : 0;
    if (o == 7'h33 || o == 7'h13) begin
      case (f)
        3'd0: return (o == 7'h33 && i[30]) ? 12 : 0;
        3'd1: return 1;
        3'd2: return 2;
        3'd3: return 11;
        3'd4: return 4;
        3'd5: return i[30] ? 13 : 5;
        3'd6: return 6;
        default: return 7;
      endcase
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= 4; k++) begin
        mv[k] = 1'b0;
        mi[k] = '0;
      end
      mpc = '0;
      ea0 = 0; eb0 = 0; ea1 = 0; eb1 = 0;
    end else begin
      m_s   = mstall();
      m_acc = in_valid && !m_s && !flush;
      ea0 = (m_acc && use1(instr_in)) ? find(instr_in[19:15], 2) : 0;
      ea1 = (m_acc && use1(instr_in)) ? find(instr_in[19:15], 4) : 0;
      eb0 = (m_acc && use2(instr_in)) ? find(instr_in[24:20], 2) : 0;
      eb1 = (m_acc && use2(instr_in)) ? find(instr_in[24:20], 4) : 0;
      for (int k = 4; k >= 2; k--) begin
        mv[k] = mv[k-1];
        mi[k] = mi[k-1];
      end
      mv[1] = m_acc;
      mi[1] = m_acc ? instr_in : '0;
      mpc   = m_acc ? pc_in : '0;
    end
  end

  always @(negedge clk) begin
    bit          v, s;
    logic [31:0] i;
    logic [6:0]  o;
    if (!rst) begin
      v = mv[1];
      i = mi[1];
      o = i[6:0];
      s = mstall();
      chk("out_valid", ov0, v);
      chk("out_valid4", ov1, v);
      chk("alu_sel", alu0, v ? exp_alu(i) : 0);
      chk("a_sel", a0, v && (o == 7'h17 || o == 7'h6f || o == 7'h63));
      chk("b_sel", b0, v && o != 7'h33);
      chk("brun", br0, v && i[13]);
      chk("mem_wen", mw0, v && o == 7'h23);
      chk("csr_we", cw0, v && o == 7'h73);
      chk("imem_ena", ie0, v && o == 7'h23 &&
          alu_result[31:29] == 3'b001 && mpc[30]);
      chk("fwd_a", fa0, ea0);
      chk("fwd_b", fb0, eb0);
      chk("fwd_a4", fa1, ea1);
      chk("fwd_b4", fb1, eb1);
      chk("stall", st0, s);
      chk("stall4", st1, s);
      chk("in_ready", rdy0, !s);
    end
  end

  function automatic logic [31:0] rt(input int f7, input int rs2,
      input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] it(input int imm, input int rs1,
      input int f3, input int rd, input logic [6:0] op);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] sw(input int rs2, input int rs1);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd2, 5'd0, 7'h23};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (n) step();
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] pc);
    in_valid = 1'b1;
    instr_in = i;
    pc_in    = pc;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] stream [14];

  initial begin
    repeat (2) @(posedge clk);
    #7 rst = 1'b0;
    chk("rst out_valid", ov0, 0);
    chk("rst in_ready", rdy0, 1);
    chk("rst fwd_a", fa0, 0);
    step();

    // back-to-back RAW on ALU result
    issue(rt(0, 3, 2, 0, 1), 32'h100);
    issue(rt(0, 1, 1, 0, 4), 32'h104);
    chk("raw fwd_a", fa0, 1);
    chk("raw fwd_b", fb0, 1);
    chk("raw fwd_a4", fa1, 1);
    idle(5);

    // load-use: one bubble then forward from distance 2
    issue(it(0, 6, 2, 5, 7'h03), 32'h200);
    in_valid = 1'b1;
    instr_in = it(1, 5, 0, 7, 7'h13);
    #1;
    chk("lu stall", st0, 1);
    chk("lu in_ready", rdy0, 0);
    step();
    chk("lu bubble", ov0, 0);
    chk("lu stall clr", st0, 0);
    step();
    in_valid = 1'b0;
    chk("lu issue", ov0, 1);
    chk("lu fwd_a", fa0, 2);
    chk("lu fwd_a4", fa1, 2);
    idle(5);

    // x0 is never a forwarding source
    issue(it(5, 0, 0, 0, 7'h13), 32'h300);
    issue(rt(0, 0, 0, 0, 8), 32'h304);
    chk("x0 fwd_a", fa0, 0);
    chk("x0 fwd_b", fb0, 0);
    idle(3);

    // IMEM write window
    alu_result = 32'h2000_0010;
    issue(sw(1, 2), 32'h4000_0000);
    chk("imem on", ie0, 1);
    issue(sw(1, 2), 32'h0000_1000);
    chk("imem off pc", ie0, 0);
    alu_result = 32'h4000_0010;
    issue(sw(1, 2), 32'h4000_0000);
    chk("imem off addr", ie0, 0);
    alu_result = '0;
    idle(5);

    // flush during stall drops the offer
    issue(it(0, 6, 2, 5, 7'h03), 32'h400);
    in_valid = 1'b1;
    instr_in = it(1, 5, 0, 7, 7'h13);
    flush    = 1'b1;
    #1;
    chk("fl stall", st0, 1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl out_valid", ov0, 0);
    step();
    chk("fl no reissue", ov0, 0);
    issue(it(1, 5, 0, 7, 7'h13), 32'h404);
    chk("fl reissue", ov0, 1);
    chk("fl fwd_a2", fa0, 0);
    chk("fl fwd_a4", fa1, 3);
    idle(5);

    // nearest of two producers wins; deep match only in 4-entry history
    issue(it(1, 0, 0, 9, 7'h13), 32'h500);
    issue(it(2, 0, 0, 11, 7'h13), 32'h504);
    issue(it(3, 0, 0, 9, 7'h13), 32'h508);
    issue(it(4, 0, 0, 12, 7'h13), 32'h50c);
    issue(rt(0, 9, 9, 0, 13), 32'h510);
    chk("k2 fwd_a4", fa1, 2);
    chk("k2 fwd_b4", fb1, 2);
    chk("k2 fwd_a", fa0, 2);
    idle(5);
    issue(it(1, 0, 0, 14, 7'h13), 32'h600);
    issue(it(0, 0, 0, 16, 7'h13), 32'h604);
    issue(it(0, 0, 0, 17, 7'h13), 32'h608);
    issue(it(0, 0, 0, 18, 7'h13), 32'h60c);
    issue(rt(0, 0, 14, 0, 15), 32'h610);
    chk("k4 fwd_a4", fa1, 4);
    chk("k4 fwd_a", fa0, 0);
    idle(5);

    // reset while stalled
    issue(it(0, 6, 2, 5, 7'h03), 32'h700);
    in_valid = 1'b1;
    instr_in = it(1, 5, 0, 7, 7'h13);
    #1;
    chk("rs stall", st0, 1);
    rst = 1'b1;
    #1;
    chk("rs out_valid", ov0, 0);
    chk("rs stall clr", st0, 0);
    chk("rs in_ready", rdy0, 1);
    chk("rs b_sel", b0, 0);
    rst = 1'b0;
    step();
    in_valid = 1'b0;
    chk("rs accept", ov0, 1);
    chk("rs fwd_a", fa0, 0);
    idle(3);

    // decode coverage
    issue(rt(32, 3, 2, 0, 5), 32'h800);
    chk("sub alu", alu0, 12);
    chk("sub b_sel", b0, 0);
    issue(it(12'h403, 1, 5, 6, 7'h13), 32'h804);
    chk("srai alu", alu0, 13);
    issue(it(12'h400, 1, 0, 6, 7'h13), 32'h808);
    chk("addi b30 alu", alu0, 0);
    issue({20'h12345, 5'd3, 7'h37}, 32'h80c);
    chk("lui alu", alu0, 15);
    issue({12'h300, 5'd1, 3'd1, 5'd2, 7'h73}, 32'h810);
    chk("csrrw alu", alu0, 8);
    chk("csrrw we", cw0, 1);
    issue({7'd0, 5'd2, 5'd1, 3'b110, 5'd0, 7'h63}, 32'h814);
    chk("bltu brun", br0, 1);
    chk("br a_sel", a0, 1);
    stream = '{rt(0, 2, 1, 1, 3), rt(0, 3, 2, 2, 4),
               rt(0, 4, 3, 3, 5), rt(0, 5, 4, 4, 6),
               rt(0, 6, 5, 5, 7), rt(32, 7, 6, 5, 8),
               rt(0, 8, 7, 6, 9), rt(0, 9, 8, 7, 10),
               {20'h1, 5'd11, 7'h17}, {20'h2, 5'd12, 7'h6f},
               it(4, 12, 0, 13, 7'h67),
               {12'h300, 5'd13, 3'd5, 5'd14, 7'h73},
               {12'h300, 5'd14, 3'd2, 5'd15, 7'h73},
               {25'h1abcd, 7'h7f}};
    foreach (stream[j]) issue(stream[j], 32'h900 + 32'(j * 4));
    issue(it(0, 10, 2, 20, 7'h03), 32'ha00);
    in_valid = 1'b1;
    instr_in = sw(20, 10);
    repeat (3) step();
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
